// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared compression-core constants and types
package common;
  localparam int COMP_CORES = 4;
  typedef logic [$clog2(COMP_CORES)-1:0] core_idx_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic single-clock FIFO with first-word-fall-through head
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; empty masks stale contents.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (int'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (int'(rd_ptr) == DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/comp_dispatch_scheduler.sv
// rtl/comp_dispatch_scheduler.sv - round-robin page dispatch to compression cores with in-order drain
module comp_dispatch_scheduler
  import common::*;
#(
  parameter int N_CORES = COMP_CORES,
  parameter int IDX_W   = $clog2(N_CORES)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [N_CORES-1:0] i_core_enable,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_in_done,
  output logic [IDX_W-1:0]   o_in_sel,
  output logic               o_in_sel_valid,
  input  logic               i_out_done,
  output logic [IDX_W-1:0]   o_out_sel,
  output logic               o_out_sel_valid,
  output logic [N_CORES-1:0] o_busy,
  output logic [IDX_W:0]     o_inflight,
  output logic               o_err
);
  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state, state_next;
  logic [N_CORES-1:0] busy, busy_next, eligible;
  logic [IDX_W-1:0]   rr_ptr, chosen, in_sel, q_head;
  logic               found, grant, q_empty, q_full, out_pop, proto_err, err;
  logic [IDX_W:0]     inflight;
  int                 idx;

  assign eligible = i_core_enable & ~busy;

  // First eligible core at or above the rr pointer, wrapping.
  always_comb begin
    chosen = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_CORES; k++) begin
      idx = (int'(rr_ptr) + k) % N_CORES;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        chosen = IDX_W'(idx);
      end
    end
  end

  assign o_req_ready = (state == IDLE) && found && !q_full;
  assign grant       = i_req_valid && o_req_ready;
  assign out_pop     = i_out_done && !q_empty;

  always_comb begin
    state_next = state;
    busy_next  = busy;
    proto_err  = 1'b0;
    if (i_out_done) begin
      if (q_empty) proto_err = 1'b1;
      else         busy_next[q_head] = 1'b0;
    end
    case (state)
      IDLE: begin
        if (grant)     state_next = STREAM;
        if (i_in_done) proto_err  = 1'b1;
      end
      STREAM: begin
        if (i_in_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (grant) busy_next[chosen] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      busy   <= '0;
      rr_ptr <= '0;
      in_sel <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      if (grant) begin
        in_sel <= chosen;
        rr_ptr <= (int'(chosen) == N_CORES - 1) ? '0 : chosen + 1'b1;
      end
      if (proto_err) err <= 1'b1;
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < N_CORES; i++) inflight = inflight + (IDX_W + 1)'(busy[i]);
  end

  sync_fifo #(.WIDTH(IDX_W), .DEPTH(N_CORES)) u_order_q (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (grant),
    .push_data (chosen),
    .pop       (out_pop),
    .head      (q_head),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign o_in_sel        = in_sel;
  assign o_in_sel_valid  = (state == STREAM);
  assign o_out_sel       = q_empty ? '0 : q_head;
  assign o_out_sel_valid = !q_empty;
  assign o_busy          = busy;
  assign o_inflight      = inflight;
  assign o_err           = err;
endmodule

// File: tb/tb_comp_dispatch_scheduler.sv
// tb/tb_comp_dispatch_scheduler.sv - self-checking bench for comp_dispatch_scheduler
module tb_comp_dispatch_scheduler;
  logic       aclk;
  logic       aresetn;
  logic [3:0] i_core_enable;
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_in_done;
  logic [1:0] o_in_sel;
  logic       o_in_sel_valid;
  logic       i_out_done;
  logic [1:0] o_out_sel;
  logic       o_out_sel_valid;
  logic [3:0] o_busy;
  logic [2:0] o_inflight;
  logic       o_err;

  int passed = 0;
  int total  = 0;

  // Reference model state
  bit [3:0] m_busy;
  int       m_q[$];
  bit       m_stream;
  int       m_rr;
  int       m_in_sel;
  bit       m_err;

  comp_dispatch_scheduler #(.N_CORES(4)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .i_core_enable   (i_core_enable),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_in_done       (i_in_done),
    .o_in_sel        (o_in_sel),
    .o_in_sel_valid  (o_in_sel_valid),
    .i_out_done      (i_out_done),
    .o_out_sel       (o_out_sel),
    .o_out_sel_valid (o_out_sel_valid),
    .o_busy          (o_busy),
    .o_inflight      (o_inflight),
    .o_err           (o_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int pick(input logic [3:0] en);
    for (int k = 0; k < 4; k++) begin
      int i = (m_rr + k) % 4;
      if (en[i] && !m_busy[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_busy = '0; m_q.delete(); m_stream = 0; m_rr = 0; m_in_sel = 0; m_err = 0;
  endfunction

  task automatic check_all();
    chk("req_ready", 32'(o_req_ready), 32'(!m_stream && pick(i_core_enable) >= 0));
    chk("out_sel_valid", 32'(o_out_sel_valid), 32'(m_q.size() > 0));
    chk("out_sel", 32'(o_out_sel), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("inflight", 32'(o_inflight), 32'($countones(m_busy)));
    chk("in_sel_valid", 32'(o_in_sel_valid), 32'(m_stream));
    chk("in_sel", 32'(o_in_sel), 32'(m_in_sel));
    chk("err", 32'(o_err), 32'(m_err));
  endtask

  // Called at a falling edge; drives one cycle, checks, advances the model, returns at next falling edge.
  task automatic cycle(input logic [3:0] en, input bit rv, input bit ind, input bit outd);
    int c;
    bit g;
    i_core_enable = en; i_req_valid = rv; i_in_done = ind; i_out_done = outd;
    #1;
    check_all();
    c = pick(en);
    g = rv && !m_stream && (c >= 0);
    if (outd) begin
      if (m_q.size() > 0) begin
        m_busy[m_q[0]] = 1'b0;
        void'(m_q.pop_front());
      end else m_err = 1;
    end
    if (ind) begin
      if (m_stream) m_stream = 0;
      else m_err = 1;
    end
    if (g) begin
      m_busy[c] = 1'b1; m_q.push_back(c); m_stream = 1; m_rr = (c + 1) % 4; m_in_sel = c;
    end
    @(posedge aclk);
    @(negedge aclk);
    i_req_valid = 0; i_in_done = 0; i_out_done = 0;
  endtask

  task automatic do_reset();
    #2 aresetn = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Grant one page, stream it for 8 cycles, then signal in-done.
  task automatic page(input logic [3:0] en, input int exp_core);
    cycle(en, 1, 0, 0);
    chk("grant_core", 32'(o_in_sel), 32'(exp_core));
    for (int i = 0; i < 7; i++) cycle(en, 0, 0, 0);
    cycle(en, 0, 1, 0);
  endtask

  initial begin
    aresetn = 1'b0; i_core_enable = 4'hf; i_req_valid = 0; i_in_done = 0; i_out_done = 0;
    model_reset();
    @(negedge aclk);
    check_all();
    aresetn = 1'b1;
    @(negedge aclk);

    for (int p = 0; p < 4; p++) page(4'hf, p);
    chk("full_busy", 32'(o_busy), 32'hf);
    chk("full_ready", 32'(o_req_ready), 32'd0);
    chk("full_head", 32'(o_out_sel), 32'd0);

    for (int p = 0; p < 4; p++) begin
      chk("drain_head", 32'(o_out_sel), 32'(p));
      cycle(4'hf, 0, 0, 1);
    end
    chk("drain_valid", 32'(o_out_sel_valid), 32'd0);
    chk("drain_busy", 32'(o_busy), 32'd0);
    chk("drain_inflight", 32'(o_inflight), 32'd0);

    begin
      int exp_g[3] = '{1, 3, 1};
      for (int p = 0; p < 3; p++) begin
        page(4'b1010, exp_g[p]);
        cycle(4'b1010, 0, 0, 1);
      end
    end

    do_reset();
    for (int p = 0; p < 4; p++) page(4'hf, p);
    chk("coll_inflight_pre", 32'(o_inflight), 32'd4);
    i_core_enable = 4'hf; i_req_valid = 1; i_out_done = 1;
    #1 chk("coll_ready_T", 32'(o_req_ready), 32'd0);
    cycle(4'hf, 1, 0, 1);
    chk("coll_inflight_T1", 32'(o_inflight), 32'd3);
    chk("coll_ready_T1", 32'(o_req_ready), 32'd1);
    cycle(4'hf, 1, 0, 0);
    chk("coll_grant", 32'(o_in_sel), 32'd0);
    chk("coll_inflight_T2", 32'(o_inflight), 32'd4);
    cycle(4'hf, 0, 1, 0);

    do_reset();
    cycle(4'hf, 0, 0, 1);
    chk("err_empty_pop", 32'(o_err), 32'd1);
    cycle(4'hf, 0, 1, 0);
    cycle(4'hf, 0, 0, 0);
    chk("err_sticky", 32'(o_err), 32'd1);
    chk("err_busy", 32'(o_busy), 32'd0);

    do_reset();
    page(4'hf, 0);
    cycle(4'hf, 1, 0, 0);
    cycle(4'hf, 0, 0, 0);
    chk("mid_busy", 32'(o_busy), 32'b0011);
    do_reset();
    cycle(4'hf, 1, 0, 0);
    chk("post_reset_grant", 32'(o_in_sel), 32'd0);
    cycle(4'hf, 0, 1, 0);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] en;
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hf;
      cycle(en, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0));
      if (n == 200) do_reset();
    end
    check_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/comp_dispatch_scheduler.md
COMP_DISPATCH_SCHEDULER -- requirements
Module: comp_dispatch_scheduler

Interface
REQ-001 SHALL have parameter N_CORES, default COMP_CORES (4), the number of compression cores scheduled.
REQ-002 SHALL have parameter IDX_W, default $clog2(N_CORES), the core-index width.
REQ-003 aclk  in  1  sole clock; all state on rising edge.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 i_core_enable  in  N_CORES  per-core enable mask; disabled cores are never granted.
REQ-006 i_req_valid  in  1  a new page is waiting at the input.
REQ-007 o_req_ready  out  1  a page may be granted this cycle.
REQ-008 i_in_done  in  1  pulse: last input beat of the current page was accepted.
REQ-009 o_in_sel  out  IDX_W  core receiving the current input page.
REQ-010 o_in_sel_valid  out  1  o_in_sel is valid; the input page is streaming.
REQ-011 i_out_done  in  1  pulse: last compressed beat of the head core was accepted downstream.
REQ-012 o_out_sel  out  IDX_W  core whose output must be drained next, in dispatch order.
REQ-013 o_out_sel_valid  out  1  o_out_sel is valid; at least one page is in flight.
REQ-014 o_busy  out  N_CORES  per-core busy mask, set from grant until out-done.
REQ-015 o_inflight  out  IDX_W+1  number of busy cores.
REQ-016 o_err  out  1  sticky protocol-error flag.

Function
REQ-017 Input FSM SHALL have two states, IDLE and STREAM.
- IDLE: o_in_sel_valid=0.
- STREAM: o_in_sel_valid=1.
REQ-018 A core is eligible iff i_core_enable[i] and !o_busy[i], using registered busy only.
REQ-019 o_req_ready SHALL be combinational: state==IDLE and at least one core is eligible.
REQ-020 Grant = i_req_valid && o_req_ready in cycle T. At T+1:
- state=STREAM;
- o_in_sel = chosen core;
- o_busy[chosen]=1;
- chosen index pushed to the order queue;
- rr pointer = chosen+1 mod N_CORES.
REQ-021 Choice SHALL be round-robin: first eligible core searching upward from the rr pointer, wrapping at N_CORES-1 to 0.
REQ-022 i_in_done in STREAM SHALL return the FSM to IDLE next cycle; busy is unchanged.
REQ-023 Back-to-back dispatch: the earliest next grant is the cycle after i_in_done is sampled in STREAM.
REQ-024 o_out_sel SHALL equal the order-queue head; o_out_sel_valid = queue not empty.
REQ-025 i_out_done with queue non-empty SHALL, next cycle:
- pop the head;
- clear o_busy[head].
REQ-026 A core freed by i_out_done in cycle T SHALL NOT be eligible before T+1.
REQ-027 A grant and i_out_done in the same cycle SHALL both take effect; o_inflight is net unchanged.
REQ-028 Order-queue depth SHALL be N_CORES; busy gating makes overflow impossible.
REQ-029 The following SHALL be ignored (no state change) and SHALL set o_err:
- i_out_done with the queue empty;
- i_in_done in IDLE.
REQ-030 Clearing i_core_enable[i] while core i is busy SHALL NOT abort it; it drains normally and is excluded afterwards.
REQ-031 o_inflight SHALL equal $countones(o_busy) and never exceed N_CORES.

Reset
REQ-032 On aresetn low, SHALL asynchronously set:
- state=IDLE, o_in_sel=0, o_in_sel_valid=0;
- o_busy=0, o_inflight=0, rr pointer=0;
- order queue empty (o_out_sel_valid=0), o_out_sel=0;
- o_err=0.
REQ-033 Reset mid-page SHALL discard all in-flight bookkeeping; the first grant after release goes to the lowest enabled core.

Structure
REQ-034 COMP_CORES and core-index type core_idx_t SHALL live in package common.
REQ-035 The order queue SHALL be one sub-module instance of the team's generic FIFO (WIDTH=IDX_W, DEPTH=N_CORES).
REQ-036 All other logic SHALL be local to comp_dispatch_scheduler.

Verification
REQ-037 N_CORES=4, all enabled, 4 pages each with i_in_done 8 cycles after grant and no out-done.
- Grants: cores 0,1,2,3.
- o_busy=4'b1111; o_req_ready=0; o_out_sel=0.
REQ-038 Continue REQ-037: pulse i_out_done 4 times.
- o_out_sel steps 0,1,2,3, then o_out_sel_valid=0.
- o_busy=0; o_inflight=0.
REQ-039 i_core_enable=4'b1010, 3 pages, out-done after each.
- Grants: 1,3,1; cores 0 and 2 never selected.
REQ-040 Cores 0-3 busy; i_out_done (head 0) and i_req_valid in cycle T.
- o_req_ready=0 at T.
- Grant to core 0 at T+1; o_inflight 4→3→4.
REQ-041 i_out_done with queue empty, then i_in_done in IDLE.
- o_err=1 and stays 1.
- o_busy, queue and FSM unchanged.
REQ-042 Assert aresetn low mid-page with 2 cores busy.
- All outputs at REQ-032 values immediately.
- After release, first grant goes to core 0.
